bit_stuffer: RTL and testbench
==============================

// Module: bit_stuffer
// PURPOSE
//  USB transmit bit stuffer; sits directly downstream of the crc stage.
//  - Consumes the serial stream from crc (s_out/start_b/endb) and inserts a 0 after every RUN_LEN consecutive 1s.
//  - Stalls crc through pause while a stuff bit is emitted.
//  - Forwards a framed serial stream to the NRZI encoder.
// PARAMETERS
//  RUN_LEN   6   consecutive 1s that force a stuffed 0 (USB = 6)
//  CNT_W     8   width of stuff_count
// PORTS
//  clk          in   1      system clock, all state on posedge
//  rst          in   1      synchronous reset, active-high
//  s_in         in   1      serial data bit from crc s_out
//  start_b      in   1      high with first bit of a packet
//  endb         in   1      high with last bit of a packet
//  pause        out  1      to crc: hold current bit and endb; not consumed this cycle
//  s_out        out  1      stuffed serial bit to NRZI
//  out_valid    out  1      s_out carries a packet bit this cycle
//  out_start    out  1      first output bit of packet
//  out_end      out  1      last output bit of packet (data or stuff bit)
//  stuff_count  out  CNT_W  stuff bits inserted in current/last packet
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all outputs 0; state IDLE; ones counter 0.
//    Reset mid-packet aborts: next cycle pause=0, out_valid=0, and any pending stuff bit is dropped.
//  - Latency: all outputs registered. A bit consumed in cycle C appears on s_out in C+1.
//  - States:
//    - IDLE:  waits for start_b. start_b -> SEND, consumes bit, stuff_count<=0.
//    - SEND:  consumes one bit per cycle. Ones counter +1 on 1, cleared on 0.
//             Consuming the RUN_LEN-th consecutive 1 -> STUFF.
//             Else endb consumed -> IDLE.
//    - STUFF: one cycle. s_out=0, out_valid=1, pause=1, ones counter cleared, stuff_count+1 (saturating).
//             Input is not consumed; crc holds its bit.
//             Exits to SEND, or to IDLE if the stuffed bit followed the endb bit.
//  - pause = (state==STUFF), registered, never high two cycles in a row.
//  - Framing:
//    - out_start accompanies the first output bit.
//    - out_end accompanies the endb bit, unless that bit is the RUN_LEN-th 1. Then out_end moves to the following stuff 0.
//  - Counter run:
//    - Stuffed 0 restarts the count; a run of 2*RUN_LEN ones yields two stuff bits.
//    - Counting spans the whole packet (sync, PID, data, CRC).
//  - start_b while not IDLE: treated as a new packet. Counter and stuff_count restart, out_start re-asserted, no stuff bit for the old run.
//  - start_b and endb together: one-bit packet; out_start and out_end both high on it.
//  - Bits arriving in IDLE without start_b are ignored.
//  - stuff_count holds its value after the packet until the next start_b.
// TESTING
//  1. Reset held 3 cycles mid-idle -> all outputs 0, pause 0.
//  2. Packet 10101010 (start_b bit0, endb bit7):
//     -> same bits on s_out one cycle later, out_start on first, out_end on 8th, pause never, stuff_count=0.
//  3. Packet 11111111:
//     -> s_out 1111110 11 over 9 cycles; pause high exactly once, in the 7th output cycle; out_end on 9th; stuff_count=1.
//  4. Packet 00111111 (endb on 6th 1):
//     -> output 00111111 0; out_end on the stuffed 0, not the last 1; stuff_count=1.
//  5. Packet of 12 ones:
//     -> 14 output bits 1111110 1111110; pause twice; stuff_count=2.
//  6. rst asserted in STUFF cycle of test 3:
//     -> next cycle pause=0, out_valid=0. Fresh start_b packet 0101 then passes unmodified.

Source files
------------

// File: rtl/bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after every RUN_LEN consecutive 1s of the
// crc serial stream, stalling crc through pause while the stuff bit goes out.
module bit_stuffer #(
  parameter int RUN_LEN = 6,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             start_b,
  input  logic             endb,
  output logic             pause,
  output logic             s_out,
  output logic             out_valid,
  output logic             out_start,
  output logic             out_end,
  output logic [CNT_W-1:0] stuff_count
);

  localparam int ONES_W = $clog2(RUN_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STUFF = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [ONES_W-1:0] ones_r, ones_s, ones_base_s;
  logic              end_pend_r, end_pend_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              consume_s, run_hit_s;
  logic              s_out_r, valid_r, start_r, end_r, pause_r;
  logic              s_out_s, valid_s, start_s, end_s, pause_s;

  assign s_out       = s_out_r;
  assign out_valid   = valid_r;
  assign out_start   = start_r;
  assign out_end     = end_r;
  assign pause       = pause_r;
  assign stuff_count = cnt_r;

  // Decide whether the input bit is taken this cycle; start_b always opens a fresh packet
  always_comb begin
    consume_s   = 1'b0;
    ones_base_s = {ONES_W{1'b0}};
    if (start_b) begin
      consume_s   = 1'b1;
      ones_base_s = {ONES_W{1'b0}};
    end else if (state_r == SEND) begin
      consume_s   = 1'b1;
      ones_base_s = ones_r;
    end else begin
      consume_s   = 1'b0;
      ones_base_s = {ONES_W{1'b0}};
    end
    run_hit_s = consume_s && s_in && (ones_base_s == ONES_W'(RUN_LEN - 1));
  end

  // State register plus registered outputs and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ones_r     <= {ONES_W{1'b0}};
      end_pend_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      s_out_r    <= 1'b0;
      valid_r    <= 1'b0;
      start_r    <= 1'b0;
      end_r      <= 1'b0;
      pause_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      ones_r     <= ones_s;
      end_pend_r <= end_pend_s;
      cnt_r      <= cnt_s;
      s_out_r    <= s_out_s;
      valid_r    <= valid_s;
      start_r    <= start_s;
      end_r      <= end_s;
      pause_r    <= pause_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    if (consume_s) begin
      if (run_hit_s) begin
        state_s = STUFF;
      end else if (endb) begin
        state_s = IDLE;
      end else begin
        state_s = SEND;
      end
    end else if (state_r == STUFF) begin
      state_s = end_pend_r ? IDLE : SEND;
    end else begin
      state_s = state_r;
    end
  end

  // Output and datapath next values
  always_comb begin
    s_out_s    = 1'b0;
    valid_s    = 1'b0;
    start_s    = 1'b0;
    end_s      = 1'b0;
    pause_s    = 1'b0;
    ones_s     = ones_r;
    end_pend_s = end_pend_r;
    cnt_s      = cnt_r;
    if (consume_s) begin
      s_out_s    = s_in;
      valid_s    = 1'b1;
      start_s    = start_b;
      // When the last bit completes a run, framing end moves to the stuff bit
      end_s      = endb & ~run_hit_s;
      end_pend_s = endb & run_hit_s;
      ones_s     = s_in ? (ones_base_s + ONES_W'(1)) : {ONES_W{1'b0}};
      cnt_s      = start_b ? {CNT_W{1'b0}} : cnt_r;
    end else if (state_r == STUFF) begin
      s_out_s    = 1'b0;
      valid_s    = 1'b1;
      pause_s    = 1'b1;
      end_s      = end_pend_r;
      end_pend_s = 1'b0;
      ones_s     = {ONES_W{1'b0}};
      cnt_s      = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : (cnt_r + CNT_W'(1));
    end else begin
      s_out_s = 1'b0;
      valid_s = 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_stuffer.sv
// Directed bench for bit_stuffer; the bench plays the crc stage and holds its bit
// through every stuff cycle.
module tb_bit_stuffer;

  localparam int RUN = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s_in = 1'b0;
  logic       start_b = 1'b0;
  logic       endb = 1'b0;
  logic       pause, s_out, out_valid, out_start, out_end;
  logic [7:0] stuff_count;

  int errors = 0;
  int checks = 0;

  // obs[c] = {valid, data, start, end, pause} seen after the posedge of drive cycle c
  logic [4:0] obs     [0:31];
  logic [7:0] obs_cnt [0:31];

  bit_stuffer #(.RUN_LEN(RUN), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .start_b(start_b), .endb(endb),
    .pause(pause), .s_out(s_out), .out_valid(out_valid), .out_start(out_start),
    .out_end(out_end), .stuff_count(stuff_count)
  );

  always #5 clk = ~clk;

  // crc model: presents bits MSB-first, holds its bit during the cycle after a completed run
  task automatic drive_packet(input logic [15:0] bits, input int len, input int ncyc,
                              input int rst_at);
    int idx;
    int ones;
    bit hold;
    idx = 0; ones = 0; hold = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      rst = (c == rst_at);
      if (idx < len) begin
        s_in = bits[len-1-idx]; start_b = (idx == 0); endb = (idx == len - 1);
      end else begin
        s_in = 1'b0; start_b = 1'b0; endb = 1'b0;
      end
      @(posedge clk);
      if (c == rst_at) idx = len;
      else if (hold) hold = 1'b0;
      else if (idx < len) begin
        if (s_in) ones++; else ones = 0;
        if (ones == RUN) begin hold = 1'b1; ones = 0; end
        idx++;
      end
      @(negedge clk);
      obs[c]     = {out_valid, s_out, out_start, out_end, pause};
      obs_cnt[c] = stuff_count;
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; s_in = 1'b1; start_b = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, s_out, out_start, out_end, pause, stuff_count} !== 13'd0) begin
        errors++;
        $display("FAIL reset cyc%0d: got %b/%0d want 00000/0", c,
                 {out_valid, s_out, out_start, out_end, pause}, stuff_count);
      end
    end
    rst = 1'b0; s_in = 1'b0; start_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alternating();
    logic [15:0] ed;
    logic [4:0]  exp;
    ed = 16'b10101010;
    drive_packet(16'b10101010, 8, 10, -1);
    for (int c = 0; c < 10; c++) begin
      exp = (c < 8) ? {1'b1, ed[7-c], c == 0, c == 7, 1'b0} : 5'b00000;
      checks++;
      if (obs[c] !== exp) begin
        errors++;
        $display("FAIL alt out%0d: got %b want %b", c, obs[c], exp);
      end
    end
    checks++;
    if (obs_cnt[9] !== 8'd0) begin
      errors++;
      $display("FAIL alt stuff_count: got %0d want 0", obs_cnt[9]);
    end
  endtask

  task automatic test_all_ones();
    logic [15:0] ed, ep;
    logic [4:0]  exp;
    ed = 16'b111111011; ep = 16'b000000100;
    drive_packet(16'hFF, 8, 11, -1);
    for (int c = 0; c < 11; c++) begin
      exp = (c < 9) ? {1'b1, ed[8-c], c == 0, c == 8, ep[8-c]} : 5'b00000;
      checks++;
      if (obs[c] !== exp) begin
        errors++;
        $display("FAIL ones8 out%0d: got %b want %b", c, obs[c], exp);
      end
    end
    checks++;
    if (obs_cnt[10] !== 8'd1) begin
      errors++;
      $display("FAIL ones8 stuff_count: got %0d want 1", obs_cnt[10]);
    end
  endtask

  task automatic test_end_on_run();
    logic [15:0] ed;
    logic [4:0]  exp;
    ed = 16'b001111110;
    drive_packet(16'b00111111, 8, 11, -1);
    for (int c = 0; c < 11; c++) begin
      exp = (c < 9) ? {1'b1, ed[8-c], c == 0, c == 8, c == 8} : 5'b00000;
      checks++;
      if (obs[c] !== exp) begin
        errors++;
        $display("FAIL endrun out%0d: got %b want %b", c, obs[c], exp);
      end
    end
    checks++;
    if (obs_cnt[10] !== 8'd1) begin
      errors++;
      $display("FAIL endrun stuff_count: got %0d want 1", obs_cnt[10]);
    end
  endtask

  task automatic test_twelve_ones();
    logic [15:0] ed, ep;
    logic [4:0]  exp;
    ed = 16'b11111101111110; ep = 16'b00000010000001;
    drive_packet(16'hFFF, 12, 16, -1);
    for (int c = 0; c < 16; c++) begin
      exp = (c < 14) ? {1'b1, ed[13-c], c == 0, c == 13, ep[13-c]} : 5'b00000;
      checks++;
      if (obs[c] !== exp) begin
        errors++;
        $display("FAIL ones12 out%0d: got %b want %b", c, obs[c], exp);
      end
    end
    checks++;
    if (obs_cnt[15] !== 8'd2) begin
      errors++;
      $display("FAIL ones12 stuff_count: got %0d want 2", obs_cnt[15]);
    end
  endtask

  task automatic test_reset_in_stuff();
    logic [15:0] ed;
    logic [4:0]  exp;
    drive_packet(16'hFF, 8, 9, 6);
    for (int c = 0; c < 9; c++) begin
      exp = (c < 6) ? {1'b1, 1'b1, c == 0, 1'b0, 1'b0} : 5'b00000;
      checks++;
      if (obs[c] !== exp) begin
        errors++;
        $display("FAIL rststuff out%0d: got %b want %b", c, obs[c], exp);
      end
    end
    checks++;
    if (obs_cnt[6] !== 8'd0) begin
      errors++;
      $display("FAIL rststuff stuff_count: got %0d want 0", obs_cnt[6]);
    end
    ed = 16'b0101;
    drive_packet(16'b0101, 4, 6, -1);
    for (int c = 0; c < 6; c++) begin
      exp = (c < 4) ? {1'b1, ed[3-c], c == 0, c == 3, 1'b0} : 5'b00000;
      checks++;
      if (obs[c] !== exp) begin
        errors++;
        $display("FAIL fresh out%0d: got %b want %b", c, obs[c], exp);
      end
    end
    checks++;
    if (obs_cnt[5] !== 8'd0) begin
      errors++;
      $display("FAIL fresh stuff_count: got %0d want 0", obs_cnt[5]);
    end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_all_ones();
    test_end_on_run();
    test_twelve_ones();
    test_reset_in_stuff();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
